// File: rtl/rival_fleet_if.sv
// Bundle between rival_fleet and its neighbours: frame/random/collision inputs
// and the per-slot position outputs consumed by the renderer and scoring.
interface rival_fleet_if #(
    parameter int N_RIVALS = 3,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
);
    logic                      frame_end;
    logic [7:0]                rnd;
    logic [3:0]                scroll_speed;
    logic [N_RIVALS-1:0]       collide_with_rival;
    logic [N_RIVALS*X_W-1:0]   rival_x;
    logic [N_RIVALS*Y_W-1:0]   rival_y;
    logic [N_RIVALS-1:0]       rival_active;
    logic [7:0]                passed_count;

    modport master (
        output frame_end, rnd, scroll_speed, collide_with_rival,
        input  rival_x, rival_y, rival_active, passed_count
    );

    modport slave (
        input  frame_end, rnd, scroll_speed, collide_with_rival,
        output rival_x, rival_y, rival_active, passed_count
    );
endinterface

// File: rtl/rival_fleet.sv
// N independent rival car slots: lane spawning from the random byte, per-frame
// scrolling, retire on exit or collision with cooldown, saturating pass count.
module rival_fleet #(
    parameter int N_RIVALS   = 3,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int LANE_BITS  = 2,
    parameter int LANE_X0    = 200,
    parameter int LANE_PITCH = 60,
    parameter int Y_START    = 0,
    parameter int Y_EXIT     = 372,
    parameter int MIN_GAP    = 120,
    parameter int COOLDOWN   = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    rival_fleet_if.slave bus
);
    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam int CNT_W = $clog2(N_RIVALS + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT} slot_state_t;

    slot_state_t    state_q [N_RIVALS];
    slot_state_t    state_d [N_RIVALS];
    logic [X_W-1:0] x_q     [N_RIVALS];
    logic [X_W-1:0] x_d     [N_RIVALS];
    logic [Y_W-1:0] y_q     [N_RIVALS];
    logic [Y_W-1:0] y_d     [N_RIVALS];
    logic [1:0]     spd_q   [N_RIVALS];
    logic [1:0]     spd_d   [N_RIVALS];
    logic [CD_W-1:0] cd_q   [N_RIVALS];
    logic [CD_W-1:0] cd_d   [N_RIVALS];
    logic [Y_W:0]   y_next  [N_RIVALS];

    logic                fe_q;
    logic                tick;
    logic [N_RIVALS-1:0] col_q;
    logic [N_RIVALS-1:0] col_d;
    logic [N_RIVALS-1:0] col_hit;
    logic [N_RIVALS-1:0] is_active;
    logic [7:0]          passed_q;
    logic [7:0]          passed_d;
    logic [CNT_W-1:0]    n_exit;
    logic [8:0]          passed_sum;
    logic                blocked;
    logic                found;

    logic [LANE_BITS-1:0] lane;
    logic [1:0]           new_spd;
    logic [X_W-1:0]       lane_x;
    logic                 unused_rnd;

    assign tick       = bus.frame_end & ~fe_q;
    assign lane       = bus.rnd[LANE_BITS-1:0];
    assign new_spd    = bus.rnd[LANE_BITS+1:LANE_BITS];
    assign lane_x     = X_W'(LANE_X0 + int'(lane) * LANE_PITCH);
    assign unused_rnd = ^bus.rnd[7:LANE_BITS+2];

    // A flag on the tick cycle itself must count, so merge it with the latch.
    assign col_hit = col_q | (bus.collide_with_rival & is_active);
    assign col_d   = tick ? '0 : col_hit;

    always_comb begin
        for (int i = 0; i < N_RIVALS; i++) begin
            is_active[i] = (state_q[i] == ACTIVE);
            y_next[i]    = {1'b0, y_q[i]}
                         + (Y_W+1)'(5'(bus.scroll_speed) + 5'(spd_q[i]));
        end
    end

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that skips
        // an assignment would otherwise infer a latch.
        for (int i = 0; i < N_RIVALS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            spd_d[i]   = spd_q[i];
            cd_d[i]    = cd_q[i];
        end
        n_exit     = '0;
        blocked    = 1'b0;
        found      = 1'b0;
        passed_sum = {1'b0, passed_q};
        passed_d   = passed_q;

        if (tick) begin
            for (int i = 0; i < N_RIVALS; i++) begin
                case (state_q[i])
                    ACTIVE: begin
                        if (col_hit[i]) begin
                            state_d[i] = WAIT;
                            cd_d[i]    = CD_W'(COOLDOWN);
                            x_d[i]     = '0;
                            y_d[i]     = '0;
                        end else if (y_next[i] > (Y_W+1)'(Y_EXIT)) begin
                            state_d[i] = IDLE;
                            x_d[i]     = '0;
                            y_d[i]     = '0;
                            n_exit     = n_exit + CNT_W'(1);
                        end else begin
                            y_d[i] = y_next[i][Y_W-1:0];
                        end
                    end
                    WAIT: begin
                        cd_d[i] = cd_q[i] - CD_W'(1);
                        if (cd_q[i] <= CD_W'(1)) begin
                            cd_d[i]    = '0;
                            state_d[i] = IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            // Gap and candidate use pre-tick state, so a slot freed now waits a tick.
            for (int i = 0; i < N_RIVALS; i++) begin
                if (is_active[i] && x_q[i] == lane_x && y_q[i] < Y_W'(MIN_GAP))
                    blocked = 1'b1;
            end
            for (int i = 0; i < N_RIVALS; i++) begin
                if (!found && state_q[i] == IDLE) begin
                    found = 1'b1;
                    if (!blocked) begin
                        state_d[i] = ACTIVE;
                        x_d[i]     = lane_x;
                        y_d[i]     = Y_W'(Y_START);
                        spd_d[i]   = new_spd;
                    end
                end
            end

            passed_sum = {1'b0, passed_q} + 9'(n_exit);
            passed_d   = passed_sum[8] ? 8'hFF : passed_sum[7:0];
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fe_q     <= 1'b0;
            col_q    <= '0;
            passed_q <= '0;
            // NOTE: the slot arrays are a few flops each, not RAM, so they take reset too.
            for (int i = 0; i < N_RIVALS; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                spd_q[i]   <= '0;
                cd_q[i]    <= '0;
            end
        end else begin
            fe_q     <= bus.frame_end;
            col_q    <= col_d;
            passed_q <= passed_d;
            for (int i = 0; i < N_RIVALS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                spd_q[i]   <= spd_d[i];
                cd_q[i]    <= cd_d[i];
            end
        end
    end

    logic [N_RIVALS*X_W-1:0] x_pack;
    logic [N_RIVALS*Y_W-1:0] y_pack;

    always_comb begin
        x_pack = '0;
        y_pack = '0;
        for (int i = 0; i < N_RIVALS; i++) begin
            x_pack[i*X_W +: X_W] = x_q[i];
            y_pack[i*Y_W +: Y_W] = y_q[i];
        end
    end

    assign bus.rival_x      = x_pack;
    assign bus.rival_y      = y_pack;
    assign bus.rival_active = is_active;
    assign bus.passed_count = passed_q;
endmodule

// File: tb/tb_rival_fleet.sv
// Directed bench for rival_fleet: a checkpoint table for spawn/move/exit plus
// hand-written sequences for reset, collision cooldown, gap, edge detect, saturation.
module tb_rival_fleet;
    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    rival_fleet_if #(.N_RIVALS(3), .X_W(10), .Y_W(10)) bus ();

    rival_fleet dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         adv;
        logic [7:0] rnd;
        logic [3:0] scroll;
        logic [2:0] act;
        int         x0;
        int         y0;
        int         y1;
        int         y2;
        int         passed;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] gx(input int i);
        return 32'(bus.rival_x[i*10 +: 10]);
    endfunction

    function automatic logic [31:0] gy(input int i);
        return 32'(bus.rival_y[i*10 +: 10]);
    endfunction

    task automatic do_tick();
        @(negedge clk) bus.frame_end = 1'b1;
        @(negedge clk) bus.frame_end = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset_n = 1'b0;
        bus.collide_with_rival = '0;
        bus.frame_end = 1'b0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    initial begin
        // Spawn at x=260 (lane 1), step 2; slot 1 and 2 follow once the gap opens.
        vecs[0] = '{1,  8'h05, 4'd1, 3'b001, 260, 0,   0,   0,   0};
        vecs[1] = '{1,  8'h05, 4'd1, 3'b001, 260, 2,   0,   0,   0};
        vecs[2] = '{3,  8'h05, 4'd1, 3'b001, 260, 8,   0,   0,   0};
        vecs[3] = '{56, 8'h05, 4'd1, 3'b001, 260, 120, 0,   0,   0};
        vecs[4] = '{1,  8'h05, 4'd1, 3'b011, 260, 122, 0,   0,   0};
        vecs[5] = '{60, 8'h05, 4'd1, 3'b011, 260, 242, 120, 0,   0};
        vecs[6] = '{1,  8'h05, 4'd1, 3'b111, 260, 244, 122, 0,   0};
        vecs[7] = '{64, 8'h05, 4'd1, 3'b111, 260, 372, 250, 128, 0};
        vecs[8] = '{1,  8'h05, 4'd1, 3'b110, 0,   0,   252, 130, 1};
        vecs[9] = '{1,  8'h05, 4'd1, 3'b111, 260, 0,   254, 132, 1};

        reset_n = 1'b0;
        bus.frame_end = 1'b0;
        bus.rnd = 8'h00;
        bus.scroll_speed = 4'd0;
        bus.collide_with_rival = '0;
        repeat (2) @(negedge clk);
        check("rst_active", 32'(bus.rival_active), 0);
        check("rst_x", 32'(bus.rival_x), 0);
        check("rst_y", 32'(bus.rival_y), 0);
        check("rst_passed", 32'(bus.passed_count), 0);
        reset_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            bus.rnd = vecs[v].rnd;
            bus.scroll_speed = vecs[v].scroll;
            for (int t = 0; t < vecs[v].adv; t++) do_tick();
            check($sformatf("vec%0d_active", v), 32'(bus.rival_active), 32'(vecs[v].act));
            check($sformatf("vec%0d_x0", v), gx(0), vecs[v].x0);
            check($sformatf("vec%0d_y0", v), gy(0), vecs[v].y0);
            check($sformatf("vec%0d_y1", v), gy(1), vecs[v].y1);
            check($sformatf("vec%0d_y2", v), gy(2), vecs[v].y2);
            check($sformatf("vec%0d_passed", v), 32'(bus.passed_count), vecs[v].passed);
        end

        // Asynchronous reset mid-cycle, sampled before any clock edge.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_active", 32'(bus.rival_active), 0);
        check("async_rst_x", 32'(bus.rival_x), 0);
        check("async_rst_y", 32'(bus.rival_y), 0);
        check("async_rst_passed", 32'(bus.passed_count), 0);
        @(negedge clk) reset_n = 1'b1;

        // Collision and cooldown.
        bus.rnd = 8'h05;
        bus.scroll_speed = 4'd1;
        do_tick();
        check("col_first_spawn", 32'(bus.rival_active), 3'b001);
        @(negedge clk) bus.collide_with_rival = 3'b001;
        @(negedge clk) bus.collide_with_rival = 3'b000;
        do_tick();
        check("col_retire", 32'(bus.rival_active), 3'b000);
        check("col_x0_clear", gx(0), 0);
        do_tick();
        check("col_slot1_spawn", 32'(bus.rival_active), 3'b010);
        for (int k = 4; k <= 9; k++) begin
            if (k == 5) begin
                @(negedge clk) bus.collide_with_rival = 3'b100;
                @(negedge clk) bus.collide_with_rival = 3'b000;
            end
            do_tick();
            check($sformatf("col_wait_c%0d", k), 32'(bus.rival_active), 3'b010);
        end
        bus.rnd = 8'h06;
        do_tick();
        check("col_c10_active", 32'(bus.rival_active), 3'b110);
        check("col_c10_x2", gx(2), 320);
        check("col_c10_y1", gy(1), 14);
        // Flag raised on the tick cycle itself retires slot 1 on that tick.
        bus.rnd = 8'h07;
        @(negedge clk) begin
            bus.frame_end = 1'b1;
            bus.collide_with_rival = 3'b010;
        end
        @(negedge clk) begin
            bus.frame_end = 1'b0;
            bus.collide_with_rival = 3'b000;
        end
        check("col_c11_active", 32'(bus.rival_active), 3'b101);
        check("col_c11_x0", gx(0), 380);
        check("col_c11_x1", gx(1), 0);
        check("col_c11_y2", gy(2), 2);

        // frame_end held high for three clocks is one tick.
        @(negedge clk) bus.frame_end = 1'b1;
        repeat (3) @(negedge clk);
        bus.frame_end = 1'b0;
        check("hold_y0", gy(0), 2);
        check("hold_y2", gy(2), 4);
        do_tick();
        check("hold_next_y0", gy(0), 4);

        // Gap: slot 1 waits until slot 0 pre-tick y reaches 120.
        pulse_reset();
        bus.rnd = 8'h01;
        bus.scroll_speed = 4'd10;
        for (int k = 1; k <= 14; k++) begin
            do_tick();
            if (k < 14) begin
                check($sformatf("gap_k%0d_active", k), 32'(bus.rival_active), 3'b001);
                check($sformatf("gap_k%0d_y0", k), gy(0), 32'(10 * (k - 1)));
            end else begin
                check("gap_open_active", 32'(bus.rival_active), 3'b011);
                check("gap_open_y0", gy(0), 130);
                check("gap_open_x1", gx(1), 260);
                check("gap_open_y1", gy(1), 0);
            end
        end

        // One spawn per tick even with two idle slots.
        pulse_reset();
        bus.rnd = 8'h01;
        bus.scroll_speed = 4'd1;
        do_tick();
        check("order_t1", 32'(bus.rival_active), 3'b001);
        bus.rnd = 8'h02;
        do_tick();
        check("order_t2", 32'(bus.rival_active), 3'b011);
        check("order_t2_x1", gx(1), 320);
        bus.rnd = 8'h03;
        do_tick();
        check("order_t3", 32'(bus.rival_active), 3'b111);
        check("order_t3_x2", gx(2), 380);

        // Saturation: far more than 255 exits at step 18 with rotating lanes.
        pulse_reset();
        bus.scroll_speed = 4'd15;
        for (int k = 0; k < 4000; k++) begin
            bus.rnd = 8'h0C | 8'(k % 4);
            do_tick();
            if (k == 3499) check("sat_mid", 32'(bus.passed_count), 255);
        end
        check("sat_end", 32'(bus.passed_count), 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
